// File: rtl/prog_loader.sv
// prog_loader: boot loader in front of program RAM port 0.
//
// Accepts a program image over a valid/ready word stream and writes it densely from
// address 0 while summing the words. It then reads the whole image back, one address
// per cycle, and compares the readback sum with the stream sum. A match starts the
// processor and hands port 0 over to its fetch interface; a mismatch parks in an error
// state until the next load request.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   load_req             pulse: start a new load (honoured in IDLE, RUN, FAIL)
//   word_valid/_data/_last, word_ready
//                        upstream image stream; word_ready only high while loading
//   proc_pc, proc_read_en
//                        processor fetch port, forwarded to RAM only while running
//   ram_addr0, ram_read_en0, ram_write_en0, ram_wdata0, ram_rdata0
//                        RAM port 0 (read data arrives one cycle after read enable)
//   start                high while running (drives proc.start)
//   busy                 high while loading or verifying
//   error                high after a failed readback check
//   overflow             image filled every RAM word without a last marker
//   word_count           words accepted in the current load
//   checksum             running sum of accepted words, modulo 2^DATA_W

`timescale 1ns/1ps

module prog_loader #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              word_valid,
  input  logic [DATA_W-1:0] word_data,
  input  logic              word_last,
  output logic              word_ready,
  input  logic [ADDR_W-1:0] proc_pc,
  input  logic              proc_read_en,
  output logic [ADDR_W-1:0] ram_addr0,
  output logic              ram_read_en0,
  output logic              ram_write_en0,
  output logic [DATA_W-1:0] ram_wdata0,
  input  logic [DATA_W-1:0] ram_rdata0,
  output logic              start,
  output logic              busy,
  output logic              error,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count,
  output logic [DATA_W-1:0] checksum
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [ADDR_W:0] LastAddr = CntW'(DEPTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StVerify,
    StRun,
    StFail
  } state_e;

  state_e state_q, state_d;

  // Load-side state.
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              ovf_q, ovf_d;

  // Verify-side state. vidx_q counts cycles since entering VERIFY: it is both the
  // address being read this cycle and, offset by one, the word whose data is arriving.
  logic [ADDR_W:0]   vidx_q, vidx_d;
  logic [DATA_W-1:0] vsum_q, vsum_d;

  logic enter_load;
  logic xfer;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    csum_d        = csum_q;
    ovf_d         = ovf_q;
    vidx_d        = vidx_q;
    vsum_d        = vsum_q;
    enter_load    = 1'b0;
    xfer          = 1'b0;
    word_ready    = 1'b0;
    ram_addr0     = '0;
    ram_read_en0  = 1'b0;
    ram_write_en0 = 1'b0;
    ram_wdata0    = '0;

    unique case (state_q)
      StIdle: begin
        if (load_req) enter_load = 1'b1;
      end

      StLoad: begin
        word_ready    = 1'b1;
        xfer          = word_valid;
        ram_addr0     = count_q[ADDR_W-1:0];
        ram_wdata0    = word_data;
        ram_write_en0 = xfer;
        if (xfer) begin
          count_d = count_q + 1'b1;
          csum_d  = csum_q + word_data;
          if (word_last) begin
            state_d = StVerify;
          end else if (count_q == LastAddr) begin
            // RAM is full and the image has not ended: verify what fits, flag it.
            ovf_d   = 1'b1;
            state_d = StVerify;
          end
          vidx_d = '0;
          vsum_d = '0;
        end
      end

      StVerify: begin
        if (vidx_q < count_q) begin
          ram_read_en0 = 1'b1;
          ram_addr0    = vidx_q[ADDR_W-1:0];
        end
        // Data for address vidx_q-1 is on ram_rdata0 from cycle 1 onwards.
        if (vidx_q != '0) vsum_d = vsum_q + ram_rdata0;
        vidx_d = vidx_q + 1'b1;
        if (vidx_q == count_q) begin
          state_d = (vsum_d == csum_q) ? StRun : StFail;
        end
      end

      StRun: begin
        ram_addr0    = proc_pc;
        ram_read_en0 = proc_read_en;
        if (load_req) enter_load = 1'b1;
      end

      StFail: begin
        if (load_req) enter_load = 1'b1;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (enter_load) begin
      state_d = StLoad;
      count_d = '0;
      csum_d  = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      csum_q  <= '0;
      ovf_q   <= 1'b0;
      vidx_q  <= '0;
      vsum_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      ovf_q   <= ovf_d;
      vidx_q  <= vidx_d;
      vsum_q  <= vsum_d;
    end
  end

  // Status outputs decode directly from registered state.
  assign start      = (state_q == StRun);
  assign busy       = (state_q == StLoad) || (state_q == StVerify);
  assign error      = (state_q == StFail);
  assign overflow   = ovf_q;
  assign word_count = count_q;
  assign checksum   = csum_q;

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps

module tb_prog_loader;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_req = 1'b0;
  logic              word_valid = 1'b0;
  logic [DATA_W-1:0] word_data = '0;
  logic              word_last = 1'b0;
  logic              word_ready;
  logic [ADDR_W-1:0] proc_pc = '0;
  logic              proc_read_en = 1'b0;
  logic [ADDR_W-1:0] ram_addr0;
  logic              ram_read_en0;
  logic              ram_write_en0;
  logic [DATA_W-1:0] ram_wdata0;
  logic [DATA_W-1:0] ram_rdata0 = '0;
  logic              start;
  logic              busy;
  logic              error;
  logic              overflow;
  logic [ADDR_W:0]   word_count;
  logic [DATA_W-1:0] checksum;

  prog_loader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_req     (load_req),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_last    (word_last),
    .word_ready   (word_ready),
    .proc_pc      (proc_pc),
    .proc_read_en (proc_read_en),
    .ram_addr0    (ram_addr0),
    .ram_read_en0 (ram_read_en0),
    .ram_write_en0(ram_write_en0),
    .ram_wdata0   (ram_wdata0),
    .ram_rdata0   (ram_rdata0),
    .start        (start),
    .busy         (busy),
    .error        (error),
    .overflow     (overflow),
    .word_count   (word_count),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  // Behavioural program RAM port 0 with 1-cycle read latency, plus a poke port the
  // bench uses to corrupt a word between load and readback.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              poke_en = 1'b0;
  logic [ADDR_W-1:0] poke_addr = '0;
  logic [DATA_W-1:0] poke_data = '0;

  always @(posedge clk) begin
    if (ram_write_en0) mem[ram_addr0] <= ram_wdata0;
    if (poke_en) mem[poke_addr] <= poke_data;
    if (ram_read_en0) ram_rdata0 <= mem[ram_addr0];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard of expected RAM writes: pushed when a word is driven, popped when the
  // DUT writes.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t wr_e;

  always @(negedge clk) begin
    if (rst_n && ram_write_en0) begin
      chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        wr_e = exp_q.pop_front();
        chk("wr_addr", 32'(ram_addr0), 32'(wr_e.addr));
        chk("wr_data", 32'(ram_wdata0), 32'(wr_e.data));
      end
    end
  end

  typedef struct {
    int          n;
    logic [15:0] base;
    logic [15:0] step;
    bit          use_last;
    bit          gap;
    bit          corrupt;
    bit          req_hold;
    logic [15:0] exp_sum;
    logic [7:0]  exp_cnt;
    bit          exp_ovf;
    bit          exp_err;
  } vec_t;

  vec_t tbl [5];

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_start"}, 32'(start), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_ready"}, 32'(word_ready), 32'd0);
    chk({tag, "_count"}, 32'(word_count), 32'd0);
    chk({tag, "_sum"}, 32'(checksum), 32'd0);
    chk({tag, "_addr"}, 32'(ram_addr0), 32'd0);
    chk({tag, "_rd"}, 32'(ram_read_en0), 32'd0);
    chk({tag, "_wr"}, 32'(ram_write_en0), 32'd0);
    chk({tag, "_wdata"}, 32'(ram_wdata0), 32'd0);
  endtask

  // Full load: request, stream words, wait out verify, check final state and port 0.
  task automatic run_load(input vec_t v);
    int          cyc;
    int          pc;
    logic [15:0] w;
    logic [15:0] exp_rd;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = v.req_hold;
    for (int i = 0; i < v.n; i++) begin
      if (v.gap && i > 0) begin
        word_valid = 1'b0;
        @(negedge clk);
        chk("gap_no_write", 32'(ram_write_en0), 32'd0);
        @(posedge clk); #1;
      end
      w          = v.base + 16'(i) * v.step;
      word_valid = 1'b1;
      word_data  = w;
      word_last  = v.use_last && (i == v.n - 1);
      exp_q.push_back('{addr: ADDR_W'(i), data: w});
      @(negedge clk);
      if (i == 0) begin
        chk("enter_busy", 32'(busy), 32'd1);
        chk("enter_start", 32'(start), 32'd0);
        chk("enter_error", 32'(error), 32'd0);
        chk("enter_count", 32'(word_count), 32'd0);
        chk("enter_sum", 32'(checksum), 32'd0);
        chk("enter_ovf", 32'(overflow), 32'd0);
      end
      @(posedge clk); #1;
    end
    // In overflow, keep offering a word: it must not be taken.
    word_valid = v.exp_ovf;
    word_data  = 16'hBEEF;
    word_last  = 1'b0;
    if (v.corrupt) begin
      poke_en   = 1'b1;
      poke_addr = 7'd1;
      poke_data = 16'hDEAD;
    end
    @(negedge clk);
    chk("load_count", 32'(word_count), 32'(v.exp_cnt));
    chk("load_sum", 32'(checksum), 32'(v.exp_sum));
    chk("load_ovf", 32'(overflow), 32'(v.exp_ovf));
    chk("verify_ready", 32'(word_ready), 32'd0);
    chk("verify_busy", 32'(busy), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    cyc = 1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      poke_en = 1'b0;
      @(negedge clk);
      if (!busy) break;
      cyc++;
    end
    load_req   = 1'b0;
    word_valid = 1'b0;
    chk("verify_cycles", 32'(cyc), 32'(v.n + 1));
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_start", 32'(start), 32'(!v.exp_err));
    chk("done_error", 32'(error), 32'(v.exp_err));
    chk("done_ovf", 32'(overflow), 32'(v.exp_ovf));
    if (!v.exp_err) begin
      pc           = (v.n >= 3) ? 2 : 1;
      exp_rd       = v.base + 16'(pc) * v.step;
      proc_pc      = ADDR_W'(pc);
      proc_read_en = 1'b1;
      #1;
      chk("run_addr", 32'(ram_addr0), 32'(pc));
      chk("run_rd", 32'(ram_read_en0), 32'd1);
      chk("run_wr", 32'(ram_write_en0), 32'd0);
      @(posedge clk); #1;
      proc_read_en = 1'b0;
      @(negedge clk);
      chk("run_rdata", 32'(ram_rdata0), 32'(exp_rd));
      chk("run_start", 32'(start), 32'd1);
    end else begin
      proc_pc      = 7'd5;
      proc_read_en = 1'b1;
      #1;
      chk("fail_rd", 32'(ram_read_en0), 32'd0);
      chk("fail_addr", 32'(ram_addr0), 32'd0);
      proc_read_en = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    // n, base, step, last, gap, corrupt, req_hold, sum, count, ovf, err
    tbl[0] = '{3, 16'h1111, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0, 16'h6666, 8'd3, 1'b0, 1'b0};
    tbl[1] = '{2, 16'hFFFF, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 8'd2, 1'b0, 1'b0};
    tbl[2] = '{128, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1FC0, 8'd128, 1'b1, 1'b0};
    tbl[3] = '{3, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0006, 8'd3, 1'b0, 1'b1};
    tbl[4] = '{5, 16'h1000, 16'h0101, 1'b1, 1'b1, 1'b0, 1'b1, 16'h5A0A, 8'd5, 1'b0, 1'b0};

    // Reset state, with processor inputs that must be ignored.
    proc_pc      = 7'd9;
    proc_read_en = 1'b1;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("idle");
    proc_read_en = 1'b0;

    // Loads chain IDLE->RUN->RUN->RUN->FAIL->RUN, so later entries also cover
    // load_req from RUN and FAIL.
    for (int t = 0; t < 5; t++) run_load(tbl[t]);

    // Reset after two of five words: immediate return to idle with all outputs low.
    @(posedge clk); #1;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      word_valid = 1'b1;
      word_data  = 16'hA000 + 16'(i);
      word_last  = 1'b0;
      exp_q.push_back('{addr: ADDR_W'(i), data: 16'hA000 + 16'(i)});
      @(posedge clk); #1;
    end
    chk("midload_count", 32'(word_count), 32'd2);
    word_data = 16'hA002;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_idle_outputs("midreset");
    word_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("postreset");

    // The loader must recover cleanly from reset.
    run_load(tbl[0]);

    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
